// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : mem_io_bridge
// Brief  : Request/ready bridge from the CPU MAR/MDR path to async SRAM plus
//          memory-mapped switch/hex channels. Optional MEM_IO_BYTE_LANE_EN.
// Rev    : 1.0
// ============================================================================
module mem_io_bridge #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int SRAM_ADDR_W = 20,
    parameter int WAIT_CYC    = 0,
    parameter int IO_CH       = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Req,
    input  logic                    Wr,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [DATA_W-1:0]       Data_from_CPU,
`ifdef MEM_IO_BYTE_LANE_EN
    input  logic [1:0]              ByteSel,
`endif
    output logic [DATA_W-1:0]       Data_to_CPU,
    output logic                    Ready,
    output logic                    Busy,
    input  logic [IO_CH*DATA_W-1:0] Switches,
    output logic [IO_CH*DATA_W-1:0] Hex_Out,
    output logic [SRAM_ADDR_W-1:0]  SRAM_ADDR,
    output logic                    CE,
    output logic                    OE,
    output logic                    WE,
    output logic                    UB,
    output logic                    LB,
    output logic [DATA_W-1:0]       Data_to_SRAM,
    input  logic [DATA_W-1:0]       Data_from_SRAM,
    output logic                    Drive
);

    localparam int CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state, state_n;
    logic [3:0]                cnt, cnt_n;
    logic                      wr_q, wr_n;
    logic [1:0]                bsel_q, bsel_n;
    logic [DATA_W-1:0]         dtc_q, dtc_n;
    logic                      ready_q, ready_n;
    logic                      busy_q, busy_n;
    logic [IO_CH*DATA_W-1:0]   hex_q, hex_n;
    logic [SRAM_ADDR_W-1:0]    sa_q, sa_n;
    logic                      ce_q, ce_n, oe_q, oe_n, we_q, we_n;
    logic                      ub_q, ub_n, lb_q, lb_n;
    logic [DATA_W-1:0]         dts_q, dts_n;
    logic                      drive_q, drive_n;

    logic [1:0]                sel_in;
    logic [ADDR_W-1:0]         addr_inv;
    logic                      io_hit;
    logic [CH_W-1:0]           ch_in;

`ifdef MEM_IO_BYTE_LANE_EN
    assign sel_in = ByteSel;
`else
    assign sel_in = 2'b11;
`endif

    // Channel k lives at all-ones minus k, so the inverted address is k.
    assign addr_inv = ~Addr;
    assign io_hit   = (addr_inv < ADDR_W'(IO_CH));
    assign ch_in    = addr_inv[CH_W-1:0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = wr_q;
        bsel_n  = bsel_q;
        dtc_n   = dtc_q;
        ready_n = 1'b0;
        hex_n   = hex_q;
        sa_n    = sa_q;
        ce_n    = ce_q;
        oe_n    = oe_q;
        we_n    = we_q;
        ub_n    = ub_q;
        lb_n    = lb_q;
        dts_n   = dts_q;
        drive_n = drive_q;

        case (state)
            IDLE: begin
                if (Req) begin
                    wr_n   = Wr;
                    bsel_n = sel_in;
                    if (io_hit) begin
                        state_n = DONE;
                        ready_n = 1'b1;
                        for (int k = 0; k < IO_CH; k++) begin
                            if (ch_in == CH_W'(k)) begin
                                if (!Wr) begin
                                    dtc_n = Switches[k*DATA_W +: DATA_W];
                                end else begin
                                    if (sel_in[1])
                                        hex_n[k*DATA_W+HALF +: DATA_W-HALF] = Data_from_CPU[DATA_W-1:HALF];
                                    if (sel_in[0])
                                        hex_n[k*DATA_W +: HALF] = Data_from_CPU[HALF-1:0];
                                end
                            end
                        end
                    end else begin
                        state_n = SETUP;
                        cnt_n   = 4'(WAIT_CYC);
                        sa_n    = SRAM_ADDR_W'(Addr);
                        // No byte lane selected: run the normal timing with the chip deselected.
                        ce_n    = ~(|sel_in);
                        ub_n    = ~sel_in[1];
                        lb_n    = ~sel_in[0];
                        if (Wr) begin
                            drive_n = 1'b1;
                            dts_n   = Data_from_CPU;
                        end else begin
                            oe_n    = 1'b0;
                        end
                    end
                end
            end
            SETUP: begin
                state_n = ACCESS;
                if (wr_q)
                    we_n = ~(|bsel_q);
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                    ce_n    = 1'b1;
                    oe_n    = 1'b1;
                    we_n    = 1'b1;
                    ub_n    = 1'b0;
                    lb_n    = 1'b0;
                    if (!wr_q)
                        dtc_n = Data_from_SRAM;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                drive_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            bsel_q  <= 2'b00;
            dtc_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= '0;
            sa_q    <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ub_q    <= 1'b0;
            lb_q    <= 1'b0;
            dts_q   <= '0;
            drive_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            wr_q    <= wr_n;
            bsel_q  <= bsel_n;
            dtc_q   <= dtc_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            hex_q   <= hex_n;
            sa_q    <= sa_n;
            ce_q    <= ce_n;
            oe_q    <= oe_n;
            we_q    <= we_n;
            ub_q    <= ub_n;
            lb_q    <= lb_n;
            dts_q   <= dts_n;
            drive_q <= drive_n;
        end
    end

    assign Data_to_CPU  = dtc_q;
    assign Ready        = ready_q;
    assign Busy         = busy_q;
    assign Hex_Out      = hex_q;
    assign SRAM_ADDR    = sa_q;
    assign CE           = ce_q;
    assign OE           = oe_q;
    assign WE           = we_q;
    assign UB           = ub_q;
    assign LB           = lb_q;
    assign Data_to_SRAM = dts_q;
    assign Drive        = drive_q;

endmodule
`default_nettype wire
